// File: rtl/meas_result_snapshot_if.sv
// Bus between the measurement/CSR side and meas_result_snapshot: run control,
// live result words, CSR read port and snapshot status.
interface meas_result_snapshot_if #(
  parameter int unsigned RES_NUM = 7
);
  logic                   test_start_i;
  logic                   test_done_i;
  logic                   meas_busy_i;
  logic [RES_NUM*32-1:0]  meas_result_i;
  logic [2:0]             rd_addr_i;
  logic                   rd_en_i;
  logic [31:0]            rd_data_o;
  logic [31:0]            avg_delay_o;
  logic                   result_valid_o;
  logic                   div_zero_o;
  logic                   snap_busy_o;

  modport slave (
    input  test_start_i, test_done_i, meas_busy_i, meas_result_i, rd_addr_i, rd_en_i,
    output rd_data_o, avg_delay_o, result_valid_o, div_zero_o, snap_busy_o
  );

  modport master (
    output test_start_i, test_done_i, meas_busy_i, meas_result_i, rd_addr_i, rd_en_i,
    input  rd_data_o, avg_delay_o, result_valid_o, div_zero_o, snap_busy_o
  );
endinterface

// File: rtl/meas_result_snapshot.sv
// Freezes the measurement result words once memory traffic has settled, then
// computes the mean read delay with a serial restoring divider and serves both over a CSR read port.
module meas_result_snapshot #(
  parameter int unsigned RES_NUM       = 7,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SUM_DEL_IDX   = 4,
  parameter int unsigned RD_REQ_IDX    = RES_NUM - 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  meas_result_snapshot_if.slave bus
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [RES_NUM-1:0][31:0] shadow_q;
  logic [31:0]              div_rem_q;
  logic [31:0]              div_quo_q;
  logic [31:0]              div_dsr_q;
  logic [4:0]               div_cnt_q;
  logic [31:0]              avg_q;
  logic [31:0]              rd_data_q;
  logic                     valid_q;
  logic                     dz_q;
  logic                     busy_q;

  logic [31:0] in_sum;
  logic [31:0] in_req;
  logic [32:0] rem_sh;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] rd_word;

  assign in_sum = bus.meas_result_i[SUM_DEL_IDX*32 +: 32];
  assign in_req = bus.meas_result_i[RD_REQ_IDX*32 +: 32];

  // One restoring-division step; the dividend is shifted out of the quotient
  // register MSB first while quotient bits shift in at the bottom.
  always_comb begin
    rem_sh = {div_rem_q, div_quo_q[31]};
    rem_d  = rem_sh[31:0];
    quo_d  = {div_quo_q[30:0], 1'b0};
    if (rem_sh >= {1'b0, div_dsr_q}) begin
      rem_d    = rem_sh[31:0] - div_dsr_q;
      quo_d[0] = 1'b1;
    end
  end

  always_comb begin
    rd_word = '0;
    if (32'(bus.rd_addr_i) < RES_NUM) begin
      rd_word = shadow_q[bus.rd_addr_i];
    end else if (bus.rd_addr_i == 3'd7) begin
      rd_word = avg_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      div_rem_q <= '0;
      div_quo_q <= '0;
      div_dsr_q <= '0;
      div_cnt_q <= '0;
      avg_q     <= '0;
      rd_data_q <= '0;
      valid_q   <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (bus.rd_en_i) begin
        rd_data_q <= rd_word;
      end

      // A start strobe aborts whatever is in flight; shadow words and the
      // last average stay visible until the next capture.
      if (bus.test_start_i) begin
        state_q <= S_RUN;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        dz_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
          end

          S_RUN: begin
            if (bus.test_done_i) begin
              state_q <= S_SETTLE;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end

          S_SETTLE: begin
            if (bus.meas_busy_i) begin
              cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_CAPTURE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          S_CAPTURE: begin
            shadow_q  <= bus.meas_result_i;
            div_rem_q <= '0;
            div_quo_q <= in_sum;
            div_dsr_q <= in_req;
            div_cnt_q <= '0;
            if (in_req == '0) begin
              state_q <= S_DONE;
              avg_q   <= '0;
              dz_q    <= 1'b1;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DIVIDE;
              dz_q    <= 1'b0;
            end
          end

          S_DIVIDE: begin
            div_rem_q <= rem_d;
            div_quo_q <= quo_d;
            div_cnt_q <= div_cnt_q + 1'b1;
            if (div_cnt_q == 5'd31) begin
              state_q <= S_DONE;
              avg_q   <= quo_d;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rd_data_o      = rd_data_q;
  assign bus.avg_delay_o    = avg_q;
  assign bus.result_valid_o = valid_q;
  assign bus.div_zero_o     = dz_q;
  assign bus.snap_busy_o    = busy_q;

endmodule

// File: tb/tb_meas_result_snapshot.sv
// Bench for meas_result_snapshot: vector table, abort/reset sequences and random
// runs checked against a cycle-level model of settle, capture and division.
module tb_meas_result_snapshot;

  localparam int unsigned RES_NUM = 7;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned SUM_IDX = 4;
  localparam int unsigned REQ_IDX = 6;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  meas_result_snapshot_if #(.RES_NUM(RES_NUM)) bus ();

  meas_result_snapshot #(
    .RES_NUM      (RES_NUM),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] sum;
    logic [31:0] req;
    logic [15:0] patt;
    int unsigned plen;
    logic [31:0] avg;
    logic        dz;
  } vec_t;

  vec_t        vecs [9];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_shadow [RES_NUM];
  logic [31:0] m_avg;
  logic [31:0] w [RES_NUM];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic pack_words();
    for (int k = 0; k < int'(RES_NUM); k++) bus.meas_result_i[k*32 +: 32] = w[k];
  endtask

  task automatic drive_words();
    for (int k = 0; k < int'(RES_NUM); k++) w[k] = $urandom;
    pack_words();
  endtask

  task automatic tick_rand(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive_words();
      tick();
    end
  endtask

  // Drives start, done and a SETTLE busy pattern; the model predicts the capture
  // cycle (SETTLE consecutive idle cycles) and places sum/req only in that cycle.
  task automatic run_to_capture(input logic [31:0] sum, input logic [31:0] req,
                                input logic [15:0] patt, input int unsigned plen);
    int unsigned idle;
    int unsigned i;
    bit          found;
    logic        b;
    idle  = 0;
    i     = 0;
    found = 0;
    bus.test_start_i = 1'b1;
    drive_words();
    tick();
    bus.test_start_i = 1'b0;
    chk("start_valid", bus.result_valid_o, 0);
    chk("start_dz", bus.div_zero_o, 0);
    chk("start_busy", bus.snap_busy_o, 0);
    bus.test_done_i = 1'b1;
    tick();
    bus.test_done_i = 1'b0;
    chk("settle_busy", bus.snap_busy_o, 1);
    while (!found && i < 64) begin
      b = (i < plen) ? patt[i[3:0]] : 1'b0;
      bus.meas_busy_i = b;
      drive_words();
      idle = b ? 0 : idle + 1;
      tick();
      i++;
      if (idle == SETTLE) found = 1;
    end
    bus.meas_busy_i = 1'b0;
    drive_words();
    w[SUM_IDX] = sum;
    w[REQ_IDX] = req;
    pack_words();
    for (int k = 0; k < int'(RES_NUM); k++) m_shadow[k] = w[k];
    chk("capture_busy", bus.snap_busy_o, 1);
    chk("capture_valid", bus.result_valid_o, 0);
    tick();
  endtask

  task automatic finish_run(input logic [31:0] exp_avg, input logic exp_dz);
    int unsigned n;
    int unsigned lat;
    n   = 1;
    lat = exp_dz ? 1 : 33;
    while (bus.result_valid_o !== 1'b1 && n < 80) begin
      drive_words();
      tick();
      n++;
    end
    chk("latency", n, lat);
    chk("valid", bus.result_valid_o, 1);
    chk("avg", bus.avg_delay_o, exp_avg);
    chk("div_zero", bus.div_zero_o, exp_dz);
    chk("done_busy", bus.snap_busy_o, 0);
    m_avg = exp_avg;
  endtask

  task automatic readout(input string tag);
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr_i = 3'(a);
      bus.rd_en_i   = 1'b1;
      drive_words();
      tick();
      bus.rd_en_i = 1'b0;
      chk($sformatf("%s_rd%0d", tag, a), bus.rd_data_o, (a < int'(RES_NUM)) ? m_shadow[a] : m_avg);
    end
    bus.rd_addr_i = 3'd0;
    drive_words();
    tick();
    chk({tag, "_rd_hold"}, bus.rd_data_o, m_avg);
  endtask

  initial begin
    logic [31:0] rs, rq, ra;
    int unsigned sel;

    vecs[0] = '{sum: 32'd1000,       req: 32'd8,          patt: 16'h0000, plen: 0,  avg: 32'd125,        dz: 1'b0};
    vecs[1] = '{sum: 32'd55,         req: 32'd0,          patt: 16'h0000, plen: 0,  avg: 32'd0,          dz: 1'b1};
    vecs[2] = '{sum: 32'd7,          req: 32'd3,          patt: 16'h0008, plen: 8,  avg: 32'd2,          dz: 1'b0};
    vecs[3] = '{sum: 32'hFFFF_FFFF,  req: 32'd1,          patt: 16'h0000, plen: 0,  avg: 32'hFFFF_FFFF,  dz: 1'b0};
    vecs[4] = '{sum: 32'h8000_0000,  req: 32'd3,          patt: 16'h0002, plen: 4,  avg: 32'h2AAA_AAAA,  dz: 1'b0};
    vecs[5] = '{sum: 32'd5,          req: 32'd9,          patt: 16'h0000, plen: 0,  avg: 32'd0,          dz: 1'b0};
    vecs[6] = '{sum: 32'hFFFF_FFFF,  req: 32'hFFFF_FFFF,  patt: 16'h0000, plen: 0,  avg: 32'd1,          dz: 1'b0};
    vecs[7] = '{sum: 32'd100,        req: 32'd7,          patt: 16'h0155, plen: 10, avg: 32'd14,         dz: 1'b0};
    vecs[8] = '{sum: 32'd1000000,    req: 32'h0001_0000,  patt: 16'h0E00, plen: 12, avg: 32'd15,         dz: 1'b0};

    bus.test_start_i  = 1'b0;
    bus.test_done_i   = 1'b0;
    bus.meas_busy_i   = 1'b0;
    bus.meas_result_i = '0;
    bus.rd_addr_i     = 3'd0;
    bus.rd_en_i       = 1'b0;
    for (int k = 0; k < int'(RES_NUM); k++) m_shadow[k] = '0;
    m_avg = '0;

    rst_i = 1'b1;
    #1;
    chk("rst_valid", bus.result_valid_o, 0);
    chk("rst_dz", bus.div_zero_o, 0);
    chk("rst_busy", bus.snap_busy_o, 0);
    chk("rst_avg", bus.avg_delay_o, 0);
    chk("rst_rd_data", bus.rd_data_o, 0);
    tick();
    tick();
    rst_i = 1'b0;

    // test_done in IDLE must not start settling
    bus.test_done_i = 1'b1;
    tick();
    bus.test_done_i = 1'b0;
    tick_rand(6);
    chk("idle_done_ignored", bus.snap_busy_o, 0);

    foreach (vecs[v]) begin
      run_to_capture(vecs[v].sum, vecs[v].req, vecs[v].patt, vecs[v].plen);
      finish_run(vecs[v].avg, vecs[v].dz);
      readout($sformatf("vec%0d", v));
    end

    // test_done in DONE is ignored; result stays valid
    bus.test_done_i = 1'b1;
    tick();
    bus.test_done_i = 1'b0;
    tick_rand(5);
    chk("done_done_valid", bus.result_valid_o, 1);
    chk("done_done_busy", bus.snap_busy_o, 0);

    // start and done together: start wins, FSM stays in RUN
    bus.test_start_i = 1'b1;
    bus.test_done_i  = 1'b1;
    tick();
    bus.test_start_i = 1'b0;
    bus.test_done_i  = 1'b0;
    chk("both_busy", bus.snap_busy_o, 0);
    chk("both_valid", bus.result_valid_o, 0);
    tick_rand(8);
    chk("both_still_run", bus.snap_busy_o, 0);

    // abort at DIVIDE cycle 10; addr 7 keeps the previous average meanwhile
    run_to_capture(32'd5000, 32'd10, 16'h0000, 0);
    tick_rand(2);
    bus.rd_addr_i = 3'd7;
    bus.rd_en_i   = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    chk("div_rd_avg_prev", bus.rd_data_o, m_avg);
    chk("div_busy", bus.snap_busy_o, 1);
    chk("div_valid", bus.result_valid_o, 0);
    tick_rand(6);
    bus.test_start_i = 1'b1;
    tick();
    bus.test_start_i = 1'b0;
    chk("abort_valid", bus.result_valid_o, 0);
    chk("abort_busy", bus.snap_busy_o, 0);
    tick_rand(40);
    chk("abort_stays_run_valid", bus.result_valid_o, 0);
    chk("abort_stays_run_busy", bus.snap_busy_o, 0);
    chk("abort_avg_kept", bus.avg_delay_o, m_avg);
    readout("abort");
    run_to_capture(32'hFFFF_FFFF, 32'd1, 16'h0000, 0);
    finish_run(32'hFFFF_FFFF, 1'b0);

    // asynchronous reset mid-DIVIDE
    run_to_capture(32'd900, 32'd4, 16'h0000, 0);
    bus.rd_addr_i = 3'(SUM_IDX);
    bus.rd_en_i   = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    chk("prerst_rd_sum", bus.rd_data_o, 32'd900);
    tick_rand(3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", bus.result_valid_o, 0);
    chk("arst_dz", bus.div_zero_o, 0);
    chk("arst_busy", bus.snap_busy_o, 0);
    chk("arst_avg", bus.avg_delay_o, 0);
    chk("arst_rd_data", bus.rd_data_o, 0);
    for (int k = 0; k < int'(RES_NUM); k++) m_shadow[k] = '0;
    m_avg = '0;
    tick();
    rst_i = 1'b0;
    tick_rand(40);
    chk("postrst_valid", bus.result_valid_o, 0);
    readout("postrst");
    run_to_capture(32'd7, 32'd3, 16'h0000, 0);
    finish_run(32'd2, 1'b0);
    readout("postrst_run");

    // random runs against the arithmetic model
    for (int r = 0; r < 20; r++) begin
      sel = $urandom_range(0, 7);
      rs  = $urandom;
      if (sel == 0)      rq = 32'd0;
      else if (sel < 4)  rq = 32'($urandom_range(1, 50));
      else               rq = $urandom;
      if (sel == 7) rs = 32'($urandom_range(0, 1000));
      ra = (rq == 0) ? 32'd0 : rs / rq;
      run_to_capture(rs, rq, 16'($urandom), $urandom_range(0, 16));
      finish_run(ra, rq == 0);
      readout($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
